// File: rtl/cpu_mc.sv
// Multi-cycle Hack-style CPU: FETCH latches the instruction word, EXEC runs it,
// and memory-touching C-instructions stay in EXEC until mem_ready. A self-loop jump halts.
module cpu_mc #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15,
    parameter int SPEED  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  instruction,
    input  logic              instr_valid,
    input  logic [WIDTH-1:0]  inM,
    input  logic              mem_ready,
    output logic [WIDTH-1:0]  outM,
    output logic              writeM,
    output logic [ADDR_W-1:0] addressM,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    localparam int CW = (SPEED > 1) ? $clog2(SPEED) : 1;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  ir_q, ir_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              preva_q, preva_d;

    logic              tick;
    logic              is_c, a_bit, d1, d2, d3;
    logic              zx, nx, zy, ny, fn, no;
    logic [2:0]        jmp;
    logic [WIDTH-1:0]  x, y, alu_out;
    logic              zr, ng, taken, mem_acc, commit, halt_hit;
    logic [ADDR_W-1:0] pc_inc, a_target;

    assign tick  = (cnt_q == CW'(SPEED - 1));
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    assign is_c  = ir_q[WIDTH-1];
    assign a_bit = ir_q[12];
    assign zx    = ir_q[11];
    assign nx    = ir_q[10];
    assign zy    = ir_q[9];
    assign ny    = ir_q[8];
    assign fn    = ir_q[7];
    assign no    = ir_q[6];
    assign d1    = ir_q[5];
    assign d2    = ir_q[4];
    assign d3    = ir_q[3];
    assign jmp   = ir_q[2:0];

    always_comb begin
        x = d_q;
        y = a_bit ? inM : a_q;
        if (zx) x = '0;
        if (nx) x = ~x;
        if (zy) y = '0;
        if (ny) y = ~y;
        alu_out = fn ? (x + y) : (x & y);
        if (no) alu_out = ~alu_out;
    end

    assign zr       = (alu_out == '0);
    assign ng       = alu_out[WIDTH-1];
    assign taken    = (jmp[2] && ng) || (jmp[1] && zr) || (jmp[0] && !ng && !zr);
    assign mem_acc  = a_bit || d3;
    assign commit   = (state_q == S_EXEC) && is_c && (!mem_acc || mem_ready);
    assign pc_inc   = pc_q + ADDR_W'(1);
    // Jump target and memory address always come from A as it was before this commit.
    assign a_target = a_q[ADDR_W-1:0];
    assign halt_hit = (jmp == 3'b111) && preva_q && (a_target == pc_q - ADDR_W'(1));

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        d_d     = d_q;
        pc_d    = pc_q;
        preva_d = preva_q;
        case (state_q)
            S_FETCH: begin
                if (tick && instr_valid) begin
                    ir_d    = instruction;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!is_c) begin
                    a_d     = {1'b0, ir_q[WIDTH-2:0]};
                    pc_d    = pc_inc;
                    preva_d = 1'b1;
                    state_d = S_FETCH;
                end else if (commit) begin
                    if (d1) a_d = alu_out;
                    if (d2) d_d = alu_out;
                    preva_d = 1'b0;
                    if (halt_hit) begin
                        pc_d    = a_target;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = taken ? a_target : pc_inc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT:  ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            a_q     <= '0;
            d_q     <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            preva_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            d_q     <= d_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            preva_q <= preva_d;
        end
    end

    // writeM follows the registered state so an async reset drops it immediately.
    assign writeM   = (state_q == S_EXEC) && is_c && d3;
    assign outM     = alu_out;
    assign addressM = a_q[ADDR_W-1:0];
    assign pc       = pc_q;
    assign halted   = (state_q == S_HALT);
endmodule

// File: doc/cpu_mc.md
CPU_MC -- requirements
Module: cpu_mc

Interface
REQ-001 Parameter WIDTH, default 16, data path, A/D register and instruction width; WIDTH >= 8.
REQ-002 Parameter ADDR_W, default 15, memory address and program counter width; ADDR_W <= WIDTH-1.
REQ-003 Parameter SPEED, default 1, clock cycles per fetch tick (execution throttle); SPEED >= 1.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 instruction  in  WIDTH  instruction word at address pc.
REQ-007 instr_valid  in  1  instruction port holds the word for the current pc.
REQ-008 inM  in  WIDTH  data memory read value at addressM.
REQ-009 mem_ready  in  1  data memory access complete this cycle.
REQ-010 outM  out  WIDTH  ALU result, the write data.
REQ-011 writeM  out  1  data memory write strobe.
REQ-012 addressM  out  ADDR_W  data memory address, equal to A[ADDR_W-1:0].
REQ-013 pc  out  ADDR_W  program counter.
REQ-014 halted  out  1  CPU is in HALT state.

Function
REQ-015 States: FETCH, EXEC, HALT. Internal registers: IR (WIDTH), A (WIDTH), D (WIDTH), PC (ADDR_W), tick counter, prev_a flag.
REQ-016 Tick counter runs free mod SPEED. tick is high when count == SPEED-1. With SPEED=1, tick is always high.
REQ-017 FETCH: when tick && instr_valid, IR <= instruction and state goes to EXEC. Otherwise the CPU stays in FETCH and holds every register.
REQ-018 A-instruction (IR[WIDTH-1]=0), in EXEC: A <= {0, IR[WIDTH-2:0]}; PC <= PC+1; prev_a <= 1; state goes to FETCH. This takes one cycle and ignores mem_ready.
REQ-019 C-instruction fields use Hack bit positions relative to the LSB: a=bit12, c1..c6=bits11..6, d1(A) d2(D) d3(M)=bits5..3, j1(lt) j2(eq) j3(gt)=bits2..0.
REQ-020 ALU operation: zx, nx, zy, ny, f, no on WIDTH bits. x=D; y=(a ? inM : A). The add result is truncated modulo 2^WIDTH. zr = (out==0); ng = out[WIDTH-1].
REQ-021 A C-instruction accesses memory when a=1 or d3=1. On such an instruction the CPU stays in EXEC until mem_ready=1 and commits on that cycle. A C-instruction with no memory access commits in its first EXEC cycle.
REQ-022 writeM = (state==EXEC) && C-instruction && d3. It is combinational from state and IR, and stays high for every wait cycle. outM and addressM hold stable while writeM is high.
REQ-023 On commit:
- d1: A <= out; d2: D <= out.
- jump taken = (j1&&ng) || (j2&&zr) || (j3&&!ng&&!zr).
- PC <= taken ? A_old[ADDR_W-1:0] : PC+1.
- prev_a <= 0; state goes to FETCH unless REQ-025 applies.
REQ-024 Old-A rule: addressM, the jump target and y all use the pre-commit value of A, including when d1=1.
REQ-025 Halt rule: on a commit where j=111, prev_a=1 and A_old[ADDR_W-1:0] == PC-1 (the "@L; 0;JMP" self-loop), PC <= A_old and state goes to HALT.
REQ-026 HALT: halted=1, writeM=0, all registers frozen. Only reset leaves HALT.
REQ-027 PC wraps from 2^ADDR_W-1 to 0 on increment.
REQ-028 Throughput with mem_ready=1 and instr_valid=1: one instruction per max(SPEED,2) cycles.

Reset
REQ-029 While reset=1, asynchronously: A=D=IR=PC=0, tick count=0, prev_a=0, state=FETCH; therefore writeM=0, halted=0, pc=0, addressM=0.
REQ-030 Reset asserted in EXEC mid memory wait drops writeM in the same cycle without waiting for a clock edge, and abandons the instruction with no partial commit.
REQ-031 The first FETCH tick after reset release occurs SPEED-1 cycles later.

Verification
REQ-032 SPEED=1, mem_ready=1. Program @12345 (0x3039) then D=A (0xEC10) -> D=12345, A=12345, pc=2 after 4 cycles.
REQ-033 SPEED=1. A=1000, D=11111, then M=D (0xE308) with mem_ready low for 3 cycles -> writeM=1, addressM=1000, outM=11111 held for 4 EXEC cycles; pc stays 5, then becomes 6.
REQ-034 SPEED=1. D=-1, A=14, then D;JLT (0xE304) -> pc=14. With D=0, the same instruction gives pc=old+1; D;JLE then jumps.
REQ-035 SPEED=1. At pc=20 issue @20, at pc=21 issue 0;JMP (0xEA87) -> halted=1, pc=20, writeM=0; further instruction and mem_ready activity changes nothing until reset.
REQ-036 SPEED=3. Stream of A-instructions -> pc increments exactly once per 3 cycles; instr_valid low for 5 cycles stalls pc with A unchanged.
REQ-037 Reset pulsed during the REQ-033 wait -> writeM=0 within the same cycle; pc=0, D=0 after release; no write ever occurs at address 1000.
